ddr_bw_sched: RTL and testbench

Sequencer for the DDR bandwidth-test datapath. It drives the AXI master's read and write engine command registers. On a start pulse it splits one transfer into n_chunks equal chunks at consecutive DDR addresses. For each chunk it issues one engine command, then waits for the engine's idle handshake. It times every chunk against a watchdog and reports total cycles, so software can compute bandwidth. It sits between the control-register block and the AXI master's RSTART/WSTART command inputs.

---
 rtl/ddr_bw_pkg.sv | 31 +++
 rtl/ddr_bw_wdog.sv | 28 ++
 rtl/ddr_bw_sched.sv | 153 +++++++++++++++
 tb/tb_ddr_bw_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_bw_pkg.sv
// Shared types and derived size helpers for the DDR bandwidth-test sequencer.
package ddr_bw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_NEXT,
    ST_FIN
  } state_e;

  function automatic int beat_log2(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int burst_log2(input int data_width, input int burst_length);
    return $clog2((burst_length + 1) * (data_width / 8));
  endfunction

  localparam int BB       = 64 / 8;
  localparam int BUB      = (7 + 1) * BB;
  localparam int LOG2_BB  = beat_log2(64);
  localparam int LOG2_BUB = burst_log2(64, 7);

  function automatic logic [31:0] align_down(input logic [31:0] v, input int lg);
    return (v >> lg) << lg;
  endfunction

endpackage

// File: rtl/ddr_bw_wdog.sv
// Per-chunk watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count would reach all-ones.
module ddr_bw_wdog #(
  parameter int TMO_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'({TMO_W{1'b1}} - 1);

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && cnt_q != '1) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  // Expiry coincides with the increment that lands on all-ones.
  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ddr_bw_sched.sv
// Chunked read/write command sequencer for the DDR bandwidth test: issues one
// engine command per chunk, waits for the idle handshake and times the run.
module ddr_bw_sched #(
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LENGTH = 7,
  parameter int TMO_W        = 16,
  parameter int CNT_W        = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      base_addr,
  input  logic [31:0]      chunk_bytes,
  input  logic [CNT_W-1:0] n_chunks,
  output logic             rstart,
  output logic [31:0]      raddr,
  output logic [31:0]      rlength,
  input  logic             ridle,
  output logic             wstart,
  output logic [31:0]      waddr,
  output logic [31:0]      wnburst,
  input  logic             widle,
  output logic             busy,
  output logic             done,
  output logic             err_tmo,
  output logic             err_cfg,
  output logic [CNT_W-1:0] chunks_done,
  output logic [31:0]      cycle_cnt
);
  import ddr_bw_pkg::*;

  localparam int LG_BB  = beat_log2(DATA_WIDTH);
  localparam int LG_BUB = burst_log2(DATA_WIDTH, BURST_LENGTH);

  state_e state_q, state_d;

  logic             mode_q;
  logic [31:0]      addr_q, len_q, nburst_q;
  logic [CNT_W-1:0] n_q;

  logic             rstart_q, wstart_q, busy_q, done_q, err_tmo_q, err_cfg_q;
  logic [31:0]      raddr_q, rlength_q, waddr_q, wnburst_q, cyc_q;
  logic [CNT_W-1:0] chunks_q;

  logic accept, idle_sel, wd_clr, wd_en, wd_exp, last_chunk;

  assign accept     = (state_q == ST_IDLE) && start;
  assign idle_sel   = mode_q ? widle : ridle;
  assign wd_clr     = (state_q == ST_ISSUE);
  assign wd_en      = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE);
  assign last_chunk = (chunks_q + CNT_W'(1)) == n_q;

  ddr_bw_wdog #(.TMO_W(TMO_W)) u_wdog (
    .clk_i     (aclk),
    .rst_i     (areset),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_exp)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start) state_d = ST_CHECK;
      ST_CHECK:     state_d = (n_q == '0 || len_q == '0) ? ST_FIN : ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_ACK;
      // A handshake seen in the expiry cycle still counts as progress.
      ST_WAIT_ACK: begin
        if (!idle_sel)   state_d = ST_WAIT_DONE;
        else if (wd_exp) state_d = ST_FIN;
      end
      ST_WAIT_DONE: begin
        if (idle_sel)    state_d = ST_NEXT;
        else if (wd_exp) state_d = ST_FIN;
      end
      ST_NEXT:      state_d = last_chunk ? ST_FIN : ST_ISSUE;
      ST_FIN:       state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Transfer configuration is captured only on accept, so a start while busy
  // leaves it untouched.
  always_ff @(posedge aclk) begin
    if (accept) begin
      mode_q   <= mode;
      addr_q   <= base_addr;
      n_q      <= n_chunks;
      len_q    <= align_down(chunk_bytes, mode ? LG_BUB : LG_BB);
      nburst_q <= chunk_bytes >> LG_BUB;
    end else if (state_q == ST_NEXT) begin
      addr_q <= addr_q + len_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      rstart_q  <= 1'b0;
      wstart_q  <= 1'b0;
      raddr_q   <= '0;
      rlength_q <= '0;
      waddr_q   <= '0;
      wnburst_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_tmo_q <= 1'b0;
      err_cfg_q <= 1'b0;
      chunks_q  <= '0;
      cyc_q     <= '0;
    end else begin
      state_q  <= state_d;
      rstart_q <= (state_q == ST_ISSUE) && !mode_q;
      wstart_q <= (state_q == ST_ISSUE) && mode_q;
      if (state_q == ST_ISSUE && !mode_q) begin
        raddr_q   <= addr_q;
        rlength_q <= len_q;
      end
      if (state_q == ST_ISSUE && mode_q) begin
        waddr_q   <= addr_q;
        wnburst_q <= nburst_q;
      end
      busy_q <= (state_q != ST_IDLE);
      done_q <= (state_q == ST_FIN);
      if (accept) begin
        chunks_q  <= '0;
        cyc_q     <= '0;
        err_tmo_q <= 1'b0;
        err_cfg_q <= 1'b0;
      end else begin
        if (state_q != ST_IDLE && cyc_q != '1) cyc_q <= cyc_q + 32'd1;
        if (state_q == ST_CHECK && n_q != '0 && len_q == '0) err_cfg_q <= 1'b1;
        if (wd_en && state_d == ST_FIN) err_tmo_q <= 1'b1;
        if (state_q == ST_NEXT) chunks_q <= chunks_q + CNT_W'(1);
      end
    end
  end

  assign rstart      = rstart_q;
  assign raddr       = raddr_q;
  assign rlength     = rlength_q;
  assign wstart      = wstart_q;
  assign waddr       = waddr_q;
  assign wnburst     = wnburst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_tmo     = err_tmo_q;
  assign err_cfg     = err_cfg_q;
  assign chunks_done = chunks_q;
  assign cycle_cnt   = cyc_q;

endmodule

// File: tb/tb_ddr_bw_sched.sv
// Scoreboard bench for ddr_bw_sched: expected commands and completions are
// queued by the stimulus and consumed by a negedge monitor.
module tb_ddr_bw_sched;

  localparam int ENG_D = 10;

  logic        aclk = 1'b0;
  logic        areset, start, mode, ridle, widle;
  logic [31:0] base_addr, chunk_bytes;
  logic [15:0] n_chunks;
  logic        rstart, wstart, busy, done, err_tmo, err_cfg;
  logic [31:0] raddr, rlength, waddr, wnburst, cycle_cnt;
  logic [15:0] chunks_done;

  always #5 aclk = ~aclk;

  ddr_bw_sched #(.DATA_WIDTH(64), .BURST_LENGTH(7), .TMO_W(4), .CNT_W(16)) dut (
    .aclk(aclk), .areset(areset), .start(start), .mode(mode),
    .base_addr(base_addr), .chunk_bytes(chunk_bytes), .n_chunks(n_chunks),
    .rstart(rstart), .raddr(raddr), .rlength(rlength), .ridle(ridle),
    .wstart(wstart), .waddr(waddr), .wnburst(wnburst), .widle(widle),
    .busy(busy), .done(done), .err_tmo(err_tmo), .err_cfg(err_cfg),
    .chunks_done(chunks_done), .cycle_cnt(cycle_cnt)
  );

  typedef struct { logic w; logic [31:0] addr; logic [31:0] len; } cmd_t;
  typedef struct { logic [15:0] chunks; logic tmo; logic cfg; logic [31:0] cyc; } done_t;

  cmd_t  cmd_q[$];
  done_t done_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  logic  hang = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  task automatic exp_cmd(input logic w, input logic [31:0] a, input logic [31:0] l);
    cmd_t c;
    c.w = w; c.addr = a; c.len = l;
    cmd_q.push_back(c);
  endtask

  task automatic exp_done(input logic [15:0] ch, input logic t, input logic c, input logic [31:0] cy);
    done_t d;
    d.chunks = ch; d.tmo = t; d.cfg = c; d.cyc = cy;
    done_q.push_back(d);
  endtask

  // Engine model: drops idle when it sees its start pulse and stays busy ENG_D cycles.
  initial begin
    int rcnt, wcnt;
    rcnt = 0; wcnt = 0; ridle = 1'b1; widle = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (areset) begin
        rcnt = 0; wcnt = 0; ridle = 1'b1; widle = 1'b1;
      end else begin
        if (rcnt > 0) begin rcnt--; if (rcnt == 0) ridle = 1'b1; end
        if (wcnt > 0) begin wcnt--; if (wcnt == 0) widle = 1'b1; end
        if (rstart && !hang) begin rcnt = ENG_D; ridle = 1'b0; end
        if (wstart) begin wcnt = ENG_D; widle = 1'b0; end
      end
    end
  end

  // Monitor: every command pulse and done pulse consumes one expectation.
  initial begin
    cmd_t  c;
    done_t d;
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (rstart || wstart) begin
          if (cmd_q.size() == 0) fail("unexpected_cmd");
          else begin
            c = cmd_q.pop_front();
            chk("cmd_kind", 32'(wstart), 32'(c.w));
            if (rstart) begin
              chk("raddr", raddr, c.addr);
              chk("rlength", rlength, c.len);
            end else begin
              chk("waddr", waddr, c.addr);
              chk("wnburst", wnburst, c.len);
            end
          end
        end
        if (done) begin
          if (done_q.size() == 0) fail("unexpected_done");
          else begin
            d = done_q.pop_front();
            chk("chunks_done", 32'(chunks_done), 32'(d.chunks));
            chk("err_tmo", 32'(err_tmo), 32'(d.tmo));
            chk("err_cfg", 32'(err_cfg), 32'(d.cfg));
            chk("cycle_cnt", cycle_cnt, d.cyc);
          end
        end
      end
    end
  end

  // Called at a negedge; index k counts negedges after the start was driven.
  task automatic go(input logic m, input logic [31:0] base, input logic [31:0] cb,
                    input logic [15:0] n, input int repulse_at, input int abort_at,
                    output int first_cmd, output int done_at);
    mode = m; base_addr = base; chunk_bytes = cb; n_chunks = n; start = 1'b1;
    first_cmd = -1;
    done_at   = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge aclk);
      start = (k == repulse_at);
      if (k == repulse_at) begin
        mode = ~m; base_addr = 32'hDEAD_0000; chunk_bytes = 32'd64; n_chunks = 16'd9;
      end
      if (first_cmd < 0 && (rstart || wstart)) first_cmd = k;
      if (done) begin done_at = k; break; end
      if (k == abort_at) break;
    end
    start = 1'b0;
    if (done_at < 0 && abort_at == 0) fail("done_timeout");
  endtask

  task automatic drain(input string nm);
    repeat (2) @(negedge aclk);
    chk({nm, "_cmd_left"}, 32'(cmd_q.size()), 32'd0);
    chk({nm, "_done_left"}, 32'(done_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_rstart"}, 32'(rstart), 32'd0);
    chk({nm, "_wstart"}, 32'(wstart), 32'd0);
    chk({nm, "_raddr"}, raddr, 32'd0);
    chk({nm, "_rlength"}, rlength, 32'd0);
    chk({nm, "_waddr"}, waddr, 32'd0);
    chk({nm, "_wnburst"}, wnburst, 32'd0);
    chk({nm, "_err_tmo"}, 32'(err_tmo), 32'd0);
    chk({nm, "_err_cfg"}, 32'(err_cfg), 32'd0);
    chk({nm, "_chunks"}, 32'(chunks_done), 32'd0);
    chk({nm, "_cycles"}, cycle_cnt, 32'd0);
  endtask

  initial begin
    int fc, da;
    areset = 1'b1; start = 1'b0; mode = 1'b0;
    base_addr = '0; chunk_bytes = '0; n_chunks = '0;
    repeat (3) @(negedge aclk);
    chk_all_zero("reset");
    areset = 1'b0;
    @(negedge aclk);

    // Three 4 KiB reads.
    exp_cmd(1'b0, 32'h2000_0000, 32'd4096);
    exp_cmd(1'b0, 32'h2000_1000, 32'd4096);
    exp_cmd(1'b0, 32'h2000_2000, 32'd4096);
    exp_done(16'd3, 1'b0, 1'b0, 32'd41);
    go(1'b0, 32'h2000_0000, 32'd4096, 16'd3, 0, 0, fc, da);
    chk("t1_rstart_lat", 32'(fc), 32'd3);
    chk("t1_done_at", 32'(da), 32'd42);
    drain("t1");

    // Writes of 1000 bytes: 15 bursts, 960-byte stride.
    exp_cmd(1'b1, 32'h1000_0000, 32'd15);
    exp_cmd(1'b1, 32'h1000_03C0, 32'd15);
    exp_done(16'd2, 1'b0, 1'b0, 32'd28);
    go(1'b1, 32'h1000_0000, 32'd1000, 16'd2, 0, 0, fc, da);
    chk("t2_done_at", 32'(da), 32'd29);
    drain("t2");

    // Zero chunks: done two cycles after accept, no command.
    exp_done(16'd0, 1'b0, 1'b0, 32'd2);
    go(1'b0, 32'h3000_0000, 32'd4096, 16'd0, 0, 0, fc, da);
    chk("t3a_done_at", 32'(da), 32'd3);
    chk("t3a_no_cmd", 32'(fc), 32'hFFFF_FFFF);
    drain("t3a");

    // Chunk shorter than one beat aligns to zero.
    exp_done(16'd0, 1'b0, 1'b1, 32'd2);
    go(1'b0, 32'h3000_0000, 32'd7, 16'd1, 0, 0, fc, da);
    chk("t3b_no_cmd", 32'(fc), 32'hFFFF_FFFF);
    drain("t3b");

    // Read engine never acknowledges: watchdog fires after 15 wait cycles.
    hang = 1'b1;
    exp_cmd(1'b0, 32'h5000_0000, 32'd256);
    exp_done(16'd0, 1'b1, 1'b0, 32'd18);
    go(1'b0, 32'h5000_0000, 32'd256, 16'd4, 0, 0, fc, da);
    chk("t4_done_at", 32'(da), 32'd19);
    hang = 1'b0;
    drain("t4");

    // Address wraps past 2^32.
    exp_cmd(1'b0, 32'hFFFF_F000, 32'd4096);
    exp_cmd(1'b0, 32'h0000_0000, 32'd4096);
    exp_done(16'd2, 1'b0, 1'b0, 32'd28);
    go(1'b0, 32'hFFFF_F000, 32'd4096, 16'd2, 0, 0, fc, da);
    drain("t5a");

    // A second start mid-run is ignored.
    exp_cmd(1'b0, 32'h0000_8000, 32'd256);
    exp_cmd(1'b0, 32'h0000_8100, 32'd256);
    exp_done(16'd2, 1'b0, 1'b0, 32'd28);
    go(1'b0, 32'h0000_8000, 32'd256, 16'd2, 10, 0, fc, da);
    chk("t5b_done_at", 32'(da), 32'd29);
    drain("t5b");

    // Reset during WAIT_DONE, then a fresh write transfer.
    exp_cmd(1'b0, 32'h3000_0000, 32'd512);
    go(1'b0, 32'h3000_0000, 32'd512, 16'd3, 0, 8, fc, da);
    chk("t5c_busy_mid", 32'(busy), 32'd1);
    areset = 1'b1;
    @(negedge aclk);
    chk_all_zero("t5c_rst");
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    exp_cmd(1'b1, 32'h4000_0000, 32'd10);
    exp_done(16'd1, 1'b0, 1'b0, 32'd15);
    go(1'b1, 32'h4000_0000, 32'd640, 16'd1, 0, 0, fc, da);
    chk("t5c_done_at", 32'(da), 32'd16);
    drain("t5c");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
